// File: rtl/gpu_pkg.sv
// gpu_pkg: definitions shared across the draw pipeline.
// Holds the draw opcodes, default coordinate widths, the visible screen size,
// the rect_raster FSM state encoding and the corner normaliser functions
// (used by both the rectangle rasteriser and the line engine).
package gpu_pkg;

    // Draw opcodes as issued by the command decoder
    typedef enum logic [3:0] {
        OP_CF   = 4'd0,
        OP_CD   = 4'd1,
        OP_RF   = 4'd2,
        OP_RD   = 4'd3,
        OP_LD   = 4'd4,
        OP_FU   = 4'd10,
        OP_IDLE = 4'd15
    } gpu_op_t;

    // Default coordinate widths and visible area
    localparam int unsigned GPU_XW       = 9;
    localparam int unsigned GPU_YW       = 8;
    localparam int unsigned GPU_SCREEN_W = 320;
    localparam int unsigned GPU_SCREEN_H = 240;

    // Common width the normaliser works in; callers cast to their own width
    localparam int unsigned GPU_COORD_W  = 16;

    // rect_raster sequencing states
    typedef enum logic [1:0] {
        RR_IDLE  = 2'd0,
        RR_SETUP = 2'd1,
        RR_RUN   = 2'd2,
        RR_FIN   = 2'd3
    } rr_state_t;

    // Corner normaliser: lower of two unsigned coordinates
    function automatic logic [GPU_COORD_W-1:0] span_lo(
        input logic [GPU_COORD_W-1:0] a,
        input logic [GPU_COORD_W-1:0] b
    );
        return (a < b) ? a : b;
    endfunction

    // Corner normaliser: higher of two unsigned coordinates
    function automatic logic [GPU_COORD_W-1:0] span_hi(
        input logic [GPU_COORD_W-1:0] a,
        input logic [GPU_COORD_W-1:0] b
    );
        return (a < b) ? b : a;
    endfunction

endpackage

// File: rtl/rect_raster.sv
// rect_raster: rectangle rasteriser feeding the X/Y coordinate select stage.
// Takes two corners and a mode (0 = fill / RF, 1 = outline / RD) and emits one
// pixel per valid/ready handshake in row-major order, then pulses DONE.
// Optional feature: define RECT_CLIP_EN to clip the rectangle to
// SCREEN_W x SCREEN_H; without it coordinates are used as given.
module rect_raster
    import gpu_pkg::*;
#(
    parameter int unsigned XW       = GPU_XW,
    parameter int unsigned YW       = GPU_YW,
    parameter int unsigned SCREEN_W = GPU_SCREEN_W,
    parameter int unsigned SCREEN_H = GPU_SCREEN_H
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          START,
    input  logic          MODE,
    input  logic [XW-1:0] X0,
    input  logic [XW-1:0] X1,
    input  logic [YW-1:0] Y0,
    input  logic [YW-1:0] Y1,
    input  logic          PIX_READY,
    output logic          PIX_VALID,
    output logic [XW-1:0] xOut,
    output logic [YW-1:0] yOut,
    output logic          BUSY,
    output logic          DONE
);

    rr_state_t     state_q;

    // Command captured in IDLE
    logic          mode_q;
    logic [XW-1:0] x0_q;
    logic [XW-1:0] x1_q;
    logic [YW-1:0] y0_q;
    logic [YW-1:0] y1_q;

    // Normalised (and possibly clipped) bounds, loaded in SETUP
    logic [XW-1:0] xmin_q;
    logic [XW-1:0] xmax_q;
    logic [YW-1:0] ymin_q;
    logic [YW-1:0] ymax_q;

    // Registered outputs; x_q/y_q double as the raster position counters
    logic          pix_valid_q;
    logic [XW-1:0] x_q;
    logic [YW-1:0] y_q;
    logic          busy_q;
    logic          done_q;

    // Next-state values
    logic [XW-1:0] xmin_d;
    logic [XW-1:0] xmax_d;
    logic [YW-1:0] ymin_d;
    logic [YW-1:0] ymax_d;
    logic          off_screen_d;
    logic [XW-1:0] x_next_d;
    logic [YW-1:0] y_next_d;
    logic          last_d;

`ifdef RECT_CLIP_EN
    localparam logic [XW-1:0] X_LAST = XW'(SCREEN_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(SCREEN_H - 1);
`endif

    // Normalise the captured corners into min/max bounds, clipping if enabled
    always_comb begin
        xmin_d = XW'(span_lo(GPU_COORD_W'(x0_q), GPU_COORD_W'(x1_q)));
        xmax_d = XW'(span_hi(GPU_COORD_W'(x0_q), GPU_COORD_W'(x1_q)));
        ymin_d = YW'(span_lo(GPU_COORD_W'(y0_q), GPU_COORD_W'(y1_q)));
        ymax_d = YW'(span_hi(GPU_COORD_W'(y0_q), GPU_COORD_W'(y1_q)));
`ifdef RECT_CLIP_EN
        // Rectangle starting past the visible area produces no pixels at all
        off_screen_d = (xmin_d > X_LAST) || (ymin_d > Y_LAST);
        // Clamped edge becomes the new right/bottom edge, so outlines close there
        if (xmax_d > X_LAST) begin
            xmax_d = X_LAST;
        end
        if (ymax_d > Y_LAST) begin
            ymax_d = Y_LAST;
        end
`else
        off_screen_d = 1'b0;
`endif
    end

    // Work out the pixel that follows the current one in row-major order
    always_comb begin
        last_d   = (x_q == xmax_q) && (y_q == ymax_q);
        x_next_d = x_q + XW'(1);
        y_next_d = y_q;
        if (x_q == xmax_q) begin
            // End of row: wrap to the left edge of the next row
            x_next_d = xmin_q;
            y_next_d = y_q + YW'(1);
        end else if (mode_q && (y_q > ymin_q) && (y_q < ymax_q) && (x_q == xmin_q)) begin
            // Outline interior row: only the two side pixels are drawn
            x_next_d = xmax_q;
        end
    end

    // Sequencing FSM with all outputs registered
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= RR_IDLE;
            mode_q      <= 1'b0;
            x0_q        <= '0;
            x1_q        <= '0;
            y0_q        <= '0;
            y1_q        <= '0;
            xmin_q      <= '0;
            xmax_q      <= '0;
            ymin_q      <= '0;
            ymax_q      <= '0;
            pix_valid_q <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                RR_IDLE: begin
                    done_q <= 1'b0;
                    if (START) begin
                        mode_q  <= MODE;
                        x0_q    <= X0;
                        x1_q    <= X1;
                        y0_q    <= Y0;
                        y1_q    <= Y1;
                        busy_q  <= 1'b1;
                        state_q <= RR_SETUP;
                    end
                end
                RR_SETUP: begin
                    xmin_q <= xmin_d;
                    xmax_q <= xmax_d;
                    ymin_q <= ymin_d;
                    ymax_q <= ymax_d;
                    if (off_screen_d) begin
                        done_q  <= 1'b1;
                        state_q <= RR_FIN;
                    end else begin
                        x_q         <= xmin_d;
                        y_q         <= ymin_d;
                        pix_valid_q <= 1'b1;
                        state_q     <= RR_RUN;
                    end
                end
                RR_RUN: begin
                    if (pix_valid_q && PIX_READY) begin
                        if (last_d) begin
                            pix_valid_q <= 1'b0;
                            done_q      <= 1'b1;
                            state_q     <= RR_FIN;
                        end else begin
                            x_q <= x_next_d;
                            y_q <= y_next_d;
                        end
                    end
                end
                RR_FIN: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= RR_IDLE;
                end
                default: begin
                    state_q <= RR_IDLE;
                end
            endcase
        end
    end

    assign PIX_VALID = pix_valid_q;
    assign xOut      = x_q;
    assign yOut      = y_q;
    assign BUSY      = busy_q;
    assign DONE      = done_q;

endmodule

// File: tb/tb_rect_raster.sv
// tb_rect_raster: self-checking bench for rect_raster.
// Expected pixel lists come from a set-based model: every (x,y) inside the
// normalised rectangle, kept when filling or when on one of its four edges.
module tb_rect_raster;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       START = 1'b0;
    logic       MODE = 1'b0;
    logic [8:0] X0 = '0;
    logic [8:0] X1 = '0;
    logic [7:0] Y0 = '0;
    logic [7:0] Y1 = '0;
    logic       PIX_READY = 1'b0;
    logic       PIX_VALID;
    logic [8:0] xOut;
    logic [7:0] yOut;
    logic       BUSY;
    logic       DONE;

    int n_cmp = 0;
    int n_err = 0;

    // Results of the latest job
    int got_x[$];
    int got_y[$];
    int exp_x[$];
    int exp_y[$];
    int first_valid_cyc;
    int last_xfer_cyc;
    int done_cyc;
    int stable_viol;
    int busy_viol;
    int valid_at_done;
    int post_done_bad;

    always #5 CLK = ~CLK;

    rect_raster #(.XW(9), .YW(8), .SCREEN_W(320), .SCREEN_H(240)) dut (
        .CLK(CLK), .RST(RST), .START(START), .MODE(MODE),
        .X0(X0), .X1(X1), .Y0(Y0), .Y1(Y1),
        .PIX_READY(PIX_READY), .PIX_VALID(PIX_VALID),
        .xOut(xOut), .yOut(yOut), .BUSY(BUSY), .DONE(DONE)
    );

    // Reference model: which pixels a rectangle job must produce, in order
    function automatic void build_expected(input bit mode, input int ax, input int ay,
                                           input int bx, input int by);
        int xl, xh, yl, yh;
        exp_x.delete();
        exp_y.delete();
        xl = (ax < bx) ? ax : bx;
        xh = (ax < bx) ? bx : ax;
        yl = (ay < by) ? ay : by;
        yh = (ay < by) ? by : ay;
`ifdef RECT_CLIP_EN
        if (xl > 319 || yl > 239) return;
        if (xh > 319) xh = 319;
        if (yh > 239) yh = 239;
`endif
        for (int y = yl; y <= yh; y++) begin
            for (int x = xl; x <= xh; x++) begin
                if (!mode || y == yl || y == yh || x == xl || x == xh) begin
                    exp_x.push_back(x);
                    exp_y.push_back(y);
                end
            end
        end
    endfunction

    // Drive one job and record what comes out; rdy_kind 0=always, 1=1,0,0 pattern, 2=random
    task automatic run_job(input bit mode, input int ax, input int ay, input int bx, input int by,
                           input int rdy_kind, input bit poke);
        bit rdy;
        bit prev_stall;
        bit poked;
        int px, py, budget, xfers, k;
        got_x.delete();
        got_y.delete();
        build_expected(mode, ax, ay, bx, by);
        first_valid_cyc = -1;
        last_xfer_cyc   = -1;
        done_cyc        = -1;
        stable_viol     = 0;
        busy_viol       = 0;
        valid_at_done   = 0;
        post_done_bad   = 0;
        budget = 4 * exp_x.size() + 20;
        prev_stall = 1'b0;
        poked = 1'b0;
        xfers = 0;
        k = 0;
        px = 0;
        py = 0;
        @(negedge CLK);
        MODE = mode;
        X0 = 9'(ax);
        Y0 = 8'(ay);
        X1 = 9'(bx);
        Y1 = 8'(by);
        START = 1'b1;
        PIX_READY = 1'b0;
        for (int cyc = 1; cyc <= budget; cyc++) begin
            @(negedge CLK);
            START = 1'b0;
            if (poke && !poked && xfers == 2) begin
                // New request while the job is running must be ignored
                MODE = ~mode;
                X0 = 9'($urandom_range(100, 200));
                Y0 = 8'($urandom_range(100, 200));
                X1 = 9'($urandom_range(100, 200));
                Y1 = 8'($urandom_range(100, 200));
                START = 1'b1;
                poked = 1'b1;
            end
            if (DONE === 1'b1) begin
                done_cyc = cyc;
                valid_at_done = (PIX_VALID === 1'b1);
                break;
            end
            if (BUSY !== 1'b1) busy_viol++;
            if (prev_stall && (PIX_VALID !== 1'b1 || int'(xOut) != px || int'(yOut) != py))
                stable_viol++;
            case (rdy_kind)
                0:       rdy = 1'b1;
                1:       rdy = ((k % 3) == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            if (PIX_VALID === 1'b1) k++;
            PIX_READY = rdy;
            if (PIX_VALID === 1'b1) begin
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                if (rdy) begin
                    got_x.push_back(int'(xOut));
                    got_y.push_back(int'(yOut));
                    last_xfer_cyc = cyc;
                    xfers++;
                end
            end
            prev_stall = (PIX_VALID === 1'b1) && !rdy;
            px = int'(xOut);
            py = int'(yOut);
        end
        PIX_READY = 1'b0;
        START = 1'b0;
        if (done_cyc >= 0) begin
            @(negedge CLK);
            if (DONE !== 1'b0 || BUSY !== 1'b0 || PIX_VALID !== 1'b0) post_done_bad = 1;
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        n_cmp++;
        if ({PIX_VALID, BUSY, DONE, xOut, yOut} !== 20'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got v=%b b=%b d=%b x=%0d y=%0d expected all 0",
                     PIX_VALID, BUSY, DONE, xOut, yOut);
        end
        RST = 1'b0;
        repeat (2) @(negedge CLK);
        n_cmp++;
        if ({PIX_VALID, BUSY, DONE} !== 3'b000) begin
            n_err++;
            $display("FAIL idle_after_reset: got v=%b b=%b d=%b expected 000", PIX_VALID, BUSY, DONE);
        end
    endtask

    task automatic test_fill_basic();
        int ex[4] = '{10, 11, 10, 11};
        int ey[4] = '{20, 20, 21, 21};
        run_job(1'b0, 10, 20, 11, 21, 0, 1'b0);
        n_cmp++;
        if (got_x.size() != 4) begin
            n_err++;
            $display("FAIL fill_count: got %0d expected 4", got_x.size());
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (i >= got_x.size() || got_x[i] != ex[i] || got_y[i] != ey[i]) begin
                n_err++;
                $display("FAIL fill_pixel%0d: got (%0d,%0d) expected (%0d,%0d)",
                         i, (i < got_x.size()) ? got_x[i] : -1, (i < got_y.size()) ? got_y[i] : -1, ex[i], ey[i]);
            end
        end
        n_cmp++;
        if (first_valid_cyc != 2) begin
            n_err++;
            $display("FAIL fill_latency: got %0d expected 2", first_valid_cyc);
        end
        n_cmp++;
        if (done_cyc < 0 || done_cyc != last_xfer_cyc + 1) begin
            n_err++;
            $display("FAIL fill_done_timing: got %0d expected %0d", done_cyc, last_xfer_cyc + 1);
        end
        n_cmp++;
        if (busy_viol != 0 || post_done_bad != 0 || valid_at_done != 0) begin
            n_err++;
            $display("FAIL fill_busy_done: got busy_viol=%0d post=%0d vdone=%0d expected 0 0 0",
                     busy_viol, post_done_bad, valid_at_done);
        end
    endtask

    task automatic test_outline();
        int holes;
        run_job(1'b1, 0, 0, 3, 2, 0, 1'b0);
        n_cmp++;
        if (got_x.size() != 10) begin
            n_err++;
            $display("FAIL outline_count: got %0d expected 10", got_x.size());
        end
        holes = 0;
        foreach (got_x[i]) if (got_y[i] == 1 && (got_x[i] == 1 || got_x[i] == 2)) holes++;
        n_cmp++;
        if (holes != 0) begin
            n_err++;
            $display("FAIL outline_interior: got %0d interior pixels expected 0", holes);
        end
        for (int i = 0; i < exp_x.size(); i++) begin
            n_cmp++;
            if (i >= got_x.size() || got_x[i] != exp_x[i] || got_y[i] != exp_y[i]) begin
                n_err++;
                $display("FAIL outline_pixel%0d: got (%0d,%0d) expected (%0d,%0d)",
                         i, (i < got_x.size()) ? got_x[i] : -1, (i < got_y.size()) ? got_y[i] : -1, exp_x[i], exp_y[i]);
            end
        end
    endtask

    task automatic test_swapped();
        int ex[4] = '{10, 11, 10, 11};
        int ey[4] = '{20, 20, 21, 21};
        run_job(1'b0, 11, 21, 10, 20, 0, 1'b0);
        n_cmp++;
        if (got_x.size() != 4) begin
            n_err++;
            $display("FAIL swapped_count: got %0d expected 4", got_x.size());
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (i >= got_x.size() || got_x[i] != ex[i] || got_y[i] != ey[i]) begin
                n_err++;
                $display("FAIL swapped_pixel%0d: got (%0d,%0d) expected (%0d,%0d)",
                         i, (i < got_x.size()) ? got_x[i] : -1, (i < got_y.size()) ? got_y[i] : -1, ex[i], ey[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int ex[4] = '{10, 11, 10, 11};
        int ey[4] = '{20, 20, 21, 21};
        run_job(1'b0, 10, 20, 11, 21, 1, 1'b0);
        n_cmp++;
        if (stable_viol != 0) begin
            n_err++;
            $display("FAIL bp_stable: got %0d changes while stalled expected 0", stable_viol);
        end
        n_cmp++;
        if (got_x.size() != 4) begin
            n_err++;
            $display("FAIL bp_count: got %0d expected 4", got_x.size());
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (i >= got_x.size() || got_x[i] != ex[i] || got_y[i] != ey[i]) begin
                n_err++;
                $display("FAIL bp_pixel%0d: got (%0d,%0d) expected (%0d,%0d)",
                         i, (i < got_x.size()) ? got_x[i] : -1, (i < got_y.size()) ? got_y[i] : -1, ex[i], ey[i]);
            end
        end
        n_cmp++;
        if (done_cyc < 0 || done_cyc != last_xfer_cyc + 1) begin
            n_err++;
            $display("FAIL bp_done_timing: got %0d expected %0d", done_cyc, last_xfer_cyc + 1);
        end
    endtask

    task automatic test_start_ignored();
        run_job(1'b0, 2, 3, 5, 4, 0, 1'b1);
        n_cmp++;
        if (got_x.size() != exp_x.size()) begin
            n_err++;
            $display("FAIL ignore_count: got %0d expected %0d", got_x.size(), exp_x.size());
        end
        for (int i = 0; i < exp_x.size(); i++) begin
            n_cmp++;
            if (i >= got_x.size() || got_x[i] != exp_x[i] || got_y[i] != exp_y[i]) begin
                n_err++;
                $display("FAIL ignore_pixel%0d: got (%0d,%0d) expected (%0d,%0d)",
                         i, (i < got_x.size()) ? got_x[i] : -1, (i < got_y.size()) ? got_y[i] : -1, exp_x[i], exp_y[i]);
            end
        end
        n_cmp++;
        if (post_done_bad != 0) begin
            n_err++;
            $display("FAIL ignore_no_restart: got post-done activity %0d expected 0", post_done_bad);
        end
    endtask

    task automatic test_abort();
        int done_seen;
        @(negedge CLK);
        MODE = 1'b0;
        X0 = 9'd0;
        Y0 = 8'd0;
        X1 = 9'd15;
        Y1 = 8'd15;
        START = 1'b1;
        PIX_READY = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        repeat (5) @(negedge CLK);
        RST = 1'b1;
        #1;
        n_cmp++;
        if ({PIX_VALID, BUSY, DONE, xOut, yOut} !== 20'd0) begin
            n_err++;
            $display("FAIL abort_outputs: got v=%b b=%b d=%b x=%0d y=%0d expected all 0",
                     PIX_VALID, BUSY, DONE, xOut, yOut);
        end
        done_seen = 0;
        repeat (2) begin
            @(negedge CLK);
            if (DONE !== 1'b0) done_seen++;
        end
        RST = 1'b0;
        repeat (3) begin
            @(negedge CLK);
            if (DONE !== 1'b0 || BUSY !== 1'b0 || PIX_VALID !== 1'b0) done_seen++;
        end
        PIX_READY = 1'b0;
        n_cmp++;
        if (done_seen != 0) begin
            n_err++;
            $display("FAIL abort_no_done: got %0d active cycles expected 0", done_seen);
        end
        run_job(1'b1, 7, 7, 7, 7, 0, 1'b0);
        n_cmp++;
        if (got_x.size() != 1 || got_x[0] != 7 || got_y[0] != 7) begin
            n_err++;
            $display("FAIL degenerate: got %0d pixels expected 1 at (7,7)", got_x.size());
        end
    endtask

    task automatic test_clip();
        int ax[2] = '{318, 400};
        int ay[2] = '{238, 10};
        int bx[2] = '{330, 410};
        int by[2] = '{250, 12};
        for (int t = 0; t < 2; t++) begin
            run_job(1'b0, ax[t], ay[t], bx[t], by[t], 0, 1'b0);
            n_cmp++;
            if (done_cyc < 0 || got_x.size() != exp_x.size()) begin
                n_err++;
                $display("FAIL clip%0d_count: got %0d (done %0d) expected %0d",
                         t, got_x.size(), done_cyc, exp_x.size());
            end
            for (int i = 0; i < exp_x.size(); i++) begin
                n_cmp++;
                if (i >= got_x.size() || got_x[i] != exp_x[i] || got_y[i] != exp_y[i]) begin
                    n_err++;
                    $display("FAIL clip%0d_pixel%0d: got (%0d,%0d) expected (%0d,%0d)", t,
                             i, (i < got_x.size()) ? got_x[i] : -1, (i < got_y.size()) ? got_y[i] : -1, exp_x[i], exp_y[i]);
                end
            end
`ifdef RECT_CLIP_EN
            n_cmp++;
            if (got_x.size() != ((t == 0) ? 4 : 0)) begin
                n_err++;
                $display("FAIL clip%0d_fixed_count: got %0d expected %0d", t, got_x.size(), (t == 0) ? 4 : 0);
            end
            if (t == 0 && got_x.size() == 4) begin
                n_cmp++;
                if (got_x[3] != 319 || got_y[3] != 239) begin
                    n_err++;
                    $display("FAIL clip_last: got (%0d,%0d) expected (319,239)", got_x[3], got_y[3]);
                end
            end
`endif
        end
    endtask

    task automatic test_random();
        int ax, ay, bx, by;
        bit m;
        for (int t = 0; t < 12; t++) begin
            ax = $urandom_range(0, 12);
            bx = $urandom_range(0, 12);
            ay = $urandom_range(0, 9);
            by = $urandom_range(0, 9);
            m  = 1'($urandom_range(0, 1));
            run_job(m, ax, ay, bx, by, 2, 1'b0);
            n_cmp++;
            if (done_cyc < 0 || got_x.size() != exp_x.size() || stable_viol != 0 || post_done_bad != 0) begin
                n_err++;
                $display("FAIL rnd%0d_job: got n=%0d done=%0d stall=%0d post=%0d expected n=%0d done>=0 0 0",
                         t, got_x.size(), done_cyc, stable_viol, post_done_bad, exp_x.size());
            end
            for (int i = 0; i < exp_x.size(); i++) begin
                n_cmp++;
                if (i >= got_x.size() || got_x[i] != exp_x[i] || got_y[i] != exp_y[i]) begin
                    n_err++;
                    $display("FAIL rnd%0d_pixel%0d: got (%0d,%0d) expected (%0d,%0d)", t,
                             i, (i < got_x.size()) ? got_x[i] : -1, (i < got_y.size()) ? got_y[i] : -1, exp_x[i], exp_y[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill_basic();
        test_outline();
        test_swapped();
        test_backpressure();
        test_start_ignored();
        test_abort();
        test_clip();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
